// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal shift/count register: mode encoding and helpers.
package univ_reg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DOWN = 3'b111
  } mode_e;

  // True for the modes that push a bit out of the register into SOUT.
  function automatic logic mode_shifts_out(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/univ_reg_next.sv
// Purely combinational next-state function of univ_reg: next Q and next SOUT per mode.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  q_cur,
  input  logic              sout_cur,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  q_nxt,
  output logic              sout_nxt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e mode_s;

  assign mode_s = mode_e'(mode);

  always_comb begin
    q_nxt    = q_cur;
    sout_nxt = sout_cur;
    case (mode_s)
      MODE_LOAD: q_nxt = d;
      MODE_SHL:  q_nxt = {q_cur[WIDTH-2:0], sin};
      MODE_SHR:  q_nxt = {sin, q_cur[WIDTH-1:1]};
      MODE_ROL:  q_nxt = {q_cur[WIDTH-2:0], q_cur[WIDTH-1]};
      MODE_ROR:  q_nxt = {q_cur[0], q_cur[WIDTH-1:1]};
      MODE_UP:   q_nxt = q_cur + ONE;
      MODE_DOWN: q_nxt = q_cur - ONE;
      default:   q_nxt = q_cur;
    endcase
    // Left-moving modes expel the MSB, right-moving modes the LSB.
    if (mode_shifts_out(mode_s)) begin
      sout_nxt = ((mode_s == MODE_SHL) || (mode_s == MODE_ROL)) ? q_cur[WIDTH-1] : q_cur[0];
    end
  end

endmodule

// File: rtl/univ_reg.sv
// Universal register: load / shift / rotate / count with async reset and sync clear.
// Optional registered parity output PAR when UNIV_REG_PARITY_EN is defined.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              SCLR,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]  D,
  input  logic              SIN,
  output logic [WIDTH-1:0]  Q,
  output logic              SOUT,
`ifdef UNIV_REG_PARITY_EN
  output logic              PAR,
`endif
  output logic              TC
);

  logic [WIDTH-1:0] q_q, q_d, q_nxt;
  logic             sout_q, sout_d, sout_nxt;
  mode_e            mode_s;

  assign mode_s = mode_e'(MODE);

  univ_reg_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q_cur   (q_q),
    .sout_cur(sout_q),
    .d       (D),
    .sin     (SIN),
    .mode    (MODE),
    .q_nxt   (q_nxt),
    .sout_nxt(sout_nxt)
  );

  // Clear beats enable; with EN low every piece of state holds.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (SCLR) begin
      q_d    = RST_VAL;
      sout_d = 1'b0;
    end else if (EN) begin
      q_d    = q_nxt;
      sout_d = sout_nxt;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      q_q    <= RST_VAL;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

`ifdef UNIV_REG_PARITY_EN
  logic par_q, par_d;

  assign par_d = ^q_d;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      par_q <= ^RST_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  assign PAR = par_q;
`endif

  // Gated by CLR_N so TC stays low while reset holds Q, whatever RST_VAL is.
  always_comb begin
    TC = 1'b0;
    if (CLR_N && EN) begin
      TC = ((mode_s == MODE_UP) && (&q_q)) || ((mode_s == MODE_DOWN) && !(|q_q));
    end
  end

  assign Q    = q_q;
  assign SOUT = sout_q;

endmodule

// File: doc/univ_reg.md
UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0, value of Q after reset or synchronous clear; WIDTH bits.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 CLR_N  input  1  asynchronous, active-low reset.
REQ-005 SCLR  input  1  synchronous clear, active-high.
REQ-006 EN  input  1  operation enable; 0 = hold.
REQ-007 MODE  input  3  operation select, per REQ-012.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 SIN  input  1  serial input for shift modes.
REQ-010 Q  output  WIDTH  registered contents.
REQ-011 SOUT  output  1  registered bit most recently shifted out; TC  output  1  combinational terminal-count flag.

Function
REQ-012 With EN=1 and SCLR=0, Q SHALL update on each rising CLK as follows:
- 000 hold.
- 001 load D.
- 010 shift left, SIN into bit 0.
- 011 shift right, SIN into bit WIDTH-1.
- 100 rotate left.
- 101 rotate right.
- 110 count up, modulo 2^WIDTH.
- 111 count down, modulo 2^WIDTH.
REQ-013 Priority SHALL be: CLR_N low, then SCLR, then EN=0 (hold all state), then MODE.
REQ-014 SCLR=1 SHALL load Q=RST_VAL and SOUT=0 on the next edge, regardless of EN and MODE.
REQ-015 SOUT SHALL capture the old Q[WIDTH-1] in modes 010 and 100, and the old Q[0] in modes 011 and 101; in all other modes and on hold it SHALL keep its value.
REQ-016 TC SHALL be 1 when EN=1 and either MODE=110 with Q all ones, or MODE=111 with Q all zeros; otherwise TC SHALL be 0.
REQ-017 Count wrap-around SHALL be silent: all ones +1 gives 0, and 0 -1 gives all ones, with TC asserted in the cycle before the wrap.
REQ-018 Latency: Q and SOUT SHALL reflect an operation one edge after it is sampled; there SHALL be no combinational path from D or SIN to Q or SOUT.
REQ-019 A MODE change between edges SHALL take effect at the next edge, with no pipeline state carried across modes.

Reset
REQ-020 While CLR_N=0, Q SHALL be RST_VAL, SOUT SHALL be 0, and TC SHALL be 0, independent of CLK.
REQ-021 Reset asserted mid-operation SHALL abort that operation immediately; the first update after CLR_N rises SHALL occur on the first rising CLK with CLR_N=1.

Configuration
REQ-022 Macro UNIV_REG_PARITY_EN defined: the block SHALL add output PAR (1 bit), registered, equal to the XOR of the new Q and updated on the same edge as Q. PAR SHALL be 0 under reset and after SCLR when RST_VAL has even parity, and otherwise equal to the parity of RST_VAL.
REQ-023 Macro UNIV_REG_PARITY_EN undefined: the PAR port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Shared package univ_reg_pkg SHALL hold the 3-bit mode encoding constants (MODE_HOLD ... MODE_DOWN) and the mode typedef; the bench SHALL use the same package.
REQ-025 The next-state computation SHALL be placed in one combinational sub-module, univ_reg_next (inputs Q, D, SIN, MODE; outputs next Q and next SOUT). The top SHALL hold only the registers, the priority logic and TC.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-026 Reset and async behaviour: CLR_N low mid-count with Q=0x7 -> Q=0x0, SOUT=0 at once without a clock; first edge after release with MODE=110 -> Q=0x1.
REQ-027 Load then shift: load D=0xA, then shift left with SIN=1 -> Q=0x5, SOUT=1; then shift right with SIN=0 -> Q=0x2, SOUT=1.
REQ-028 Rotate: from Q=0x9, rotate right -> Q=0xC, SOUT=1; then rotate left -> Q=0x9, SOUT=1.
REQ-029 Count wrap: from Q=0xE, count up -> Q=0xF with TC=1 -> next edge Q=0x0; from 0x0, count down -> TC=1, then Q=0xF.
REQ-030 Priority: SCLR=1 with EN=0 and Q=0x6 -> Q=0x0; EN=0 with MODE=001 and D=0xF -> Q unchanged and TC=0.
REQ-031 Parity build with RST_VAL=0x1: reset -> Q=0x1, PAR=1; then load 0x3 -> PAR=0.
